// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, fetch entry layout and the
// helper that word-aligns an address.
package cpu_pkg;
  localparam int CPU_XLEN    = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [CPU_XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [CPU_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [CPU_XLEN-1:0] align_addr(input logic [CPU_XLEN-1:0] a);
    return {a[CPU_XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_prefetch_stage_fetch_queue.sv
// Generic DEPTH-entry synchronous FIFO with combinational head read.
// flush empties the queue and takes priority over push/pop.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] hd, tl;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // Push while full is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[hd];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (do_push) tl <= tl + AW'(1);
      if (do_pop)  hd <= hd + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[tl] <= wdata;
  end
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: owns fetch_pc, reads imem combinationally and
// buffers {pc, instr} pairs toward ID; redirects flush and reload the PC.
module if_prefetch_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 6,
  parameter int DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_target,
  output logic [IMEM_AW-1:0]        imem_addr,
  input  logic [XLEN-1:0]           imem_rdata,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [XLEN-1:0]           id_instr,
  output logic [XLEN-1:0]           id_pc,
  output logic                      flush_out,
  output logic [$clog2(DEPTH):0]    q_count
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  entry_t          wr_e, hd_e;
  logic            full, empty, push, pop;

  assign flush_out = redirect_valid;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  // A redirect cycle neither consumes nor fetches; ID squashes its input.
  assign pop  = !empty && id_ready && !redirect_valid;
  assign push = !redirect_valid && (!full || pop);
  assign wr_e = '{pc: fetch_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
    else if (push)           fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
  end

  fetch_queue #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_e),
    .head  (hd_e),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  assign id_valid = !empty;
  assign id_pc    = empty ? '0 : hd_e.pc;
  assign id_instr = empty ? XLEN'(NOP_INSTR) : hd_e.instr;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch stage.
module tb_if_prefetch_stage;
  localparam int XLEN = 32, IMEM_AW = 6, DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 0;
  logic              reset, redirect_valid, id_ready;
  logic [31:0]       redirect_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]       imem_rdata, id_instr, id_pc;
  logic              id_valid, flush_out;
  logic [2:0]        q_count;

  logic [31:0] imem [1<<IMEM_AW];
  assign imem_rdata = imem[imem_addr];

  always #5 clk = ~clk;

  if_prefetch_stage #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .flush_out(flush_out), .q_count(q_count)
  );

  int checks = 0, failures = 0;

  // Reference model: a plain queue of fetched entries plus the fetch PC.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc = RESET_PC;

  task automatic drive(input logic rst, input logic rv, input logic [31:0] tgt, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_target = tgt; id_ready = rdy;
    #2;
  endtask

  task automatic cycle();
    ent_t e;
    bit   do_pop, do_push;
    @(posedge clk);
    if (reset) begin
      mq.delete(); mpc = RESET_PC;
    end else if (redirect_valid) begin
      mq.delete(); mpc = redirect_target & ~32'h3;
    end else begin
      do_pop  = (mq.size() > 0) && id_ready;
      do_push = (mq.size() < DEPTH) || do_pop;
      e.pc = mpc; e.instr = imem[mpc[IMEM_AW+1:2]];
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin mq.push_back(e); mpc = mpc + 32'd4; end
    end
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < (1<<IMEM_AW); k++) imem[k] = 32'h1000 + k;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h1234, 0);
    checks++; if (flush_out !== 1'b1) begin failures++; $display("FAIL reset_flush_out got=%0b exp=1", flush_out); end
    cycle();
    drive(1, 0, 0, 0);
    checks++; if (imem_addr !== 6'd0) begin failures++; $display("FAIL reset_over_redirect imem_addr got=%0h exp=0", imem_addr); end
    checks++; if (flush_out !== 1'b0) begin failures++; $display("FAIL reset_flush_low got=%0b exp=0", flush_out); end
    cycle();
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin failures++; $display("FAIL reset_head pc=%0h instr=%0h exp=0/0", id_pc, id_instr); end
  endtask

  task automatic test_stream();
    drive(1, 0, 0, 1); cycle();
    drive(0, 0, 0, 1);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0b exp=0", id_valid); end
    cycle();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'(32'h1000 + k) || q_count !== 3'd1) begin
        failures++;
        $display("FAIL stream_k%0d got v=%0b pc=%0h instr=%0h cnt=%0d exp v=1 pc=%0h instr=%0h cnt=1",
                 k, id_valid, id_pc, id_instr, q_count, 4*k, 32'h1000 + k);
      end
      cycle();
    end
  endtask

  task automatic test_stall_full_reset();
    drive(1, 0, 0, 0); cycle();
    for (int i = 0; i < 8; i++) begin
      int e = (i < 4) ? i : 4;
      drive(0, 0, 0, 0);
      checks++;
      if (q_count !== 3'(e) || imem_addr !== 6'(e)) begin
        failures++;
        $display("FAIL stall_i%0d got cnt=%0d addr=%0h exp cnt=%0d addr=%0h", i, q_count, imem_addr, e, e);
      end
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (id_pc !== 32'(4*k) || id_instr !== 32'(32'h1000 + k) || q_count !== 3'd4) begin
        failures++;
        $display("FAIL drain_full_k%0d got pc=%0h instr=%0h cnt=%0d exp pc=%0h instr=%0h cnt=4",
                 k, id_pc, id_instr, q_count, 4*k, 32'h1000 + k);
      end
      cycle();
    end
    drive(1, 0, 0, 1); cycle();
    drive(0, 0, 0, 1);
    checks++;
    if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_addr !== RESET_PC[IMEM_AW+1:2]) begin
      failures++;
      $display("FAIL midstream_reset got cnt=%0d v=%0b addr=%0h exp 0/0/%0h", q_count, id_valid, imem_addr, RESET_PC[IMEM_AW+1:2]);
    end
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin failures++; $display("FAIL restart_head got v=%0b pc=%0h exp v=1 pc=%0h", id_valid, id_pc, RESET_PC); end
  endtask

  task automatic test_redirect_flush();
    drive(1, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0); cycle(); end
    drive(0, 1, 32'h40, 1);
    checks++; if (flush_out !== 1'b1 || q_count !== 3'd3) begin failures++; $display("FAIL redirect_cycle got flush=%0b cnt=%0d exp 1/3", flush_out, q_count); end
    cycle();
    drive(0, 0, 0, 1);
    checks++;
    if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_addr !== 6'h10) begin
      failures++;
      $display("FAIL redirect_after got cnt=%0d v=%0b addr=%0h exp 0/0/10", q_count, id_valid, imem_addr);
    end
    cycle();
    drive(0, 0, 0, 1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h1010) begin
      failures++;
      $display("FAIL redirect_target_head got v=%0b pc=%0h instr=%0h exp 1/40/1010", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_misaligned();
    drive(0, 1, 32'h47, 1); cycle();
    drive(0, 0, 0, 1);
    checks++; if (imem_addr !== 6'h11) begin failures++; $display("FAIL misaligned_addr got=%0h exp=11", imem_addr); end
    cycle();
    drive(0, 0, 0, 1);
    checks++; if (id_pc !== 32'h44 || id_instr !== 32'h1011) begin failures++; $display("FAIL misaligned_head got pc=%0h instr=%0h exp 44/1011", id_pc, id_instr); end
    cycle();
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 32'h20, 1); cycle();
    drive(0, 1, 32'h80, 1);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap1 got v=%0b pc=%0h exp v=0", id_valid, id_pc); end
    cycle();
    drive(0, 0, 0, 1);
    checks++; if (id_valid !== 1'b0 || imem_addr !== 6'h20) begin failures++; $display("FAIL b2b_gap2 got v=%0b addr=%0h exp 0/20", id_valid, imem_addr); end
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(32'h80 + 4*k)) begin
        failures++;
        $display("FAIL b2b_head_k%0d got v=%0b pc=%0h exp 1/%0h", k, id_valid, id_pc, 32'h80 + 4*k);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] epc, ein;
    for (int k = 0; k < (1<<IMEM_AW); k++) imem[k] = $urandom;
    drive(1, 0, 0, 0); cycle();
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 9) < 7));
      epc = (mq.size() > 0) ? mq[0].pc : 32'h0;
      ein = (mq.size() > 0) ? mq[0].instr : 32'h0;
      checks++;
      if (id_valid !== (mq.size() > 0) || id_pc !== epc || id_instr !== ein ||
          q_count !== 3'(mq.size()) || imem_addr !== mpc[IMEM_AW+1:2] || flush_out !== redirect_valid) begin
        failures++;
        $display("FAIL random_n%0d got v=%0b pc=%0h instr=%0h cnt=%0d addr=%0h fl=%0b exp v=%0b pc=%0h instr=%0h cnt=%0d addr=%0h fl=%0b",
                 n, id_valid, id_pc, id_instr, q_count, imem_addr, flush_out,
                 mq.size() > 0, epc, ein, mq.size(), mpc[IMEM_AW+1:2], redirect_valid);
      end
      cycle();
    end
  endtask

  initial begin
    load_ramp();
    reset = 1; redirect_valid = 0; redirect_target = 0; id_ready = 0;
    cycle(); cycle();
    test_reset();
    test_stream();
    test_stall_full_reset();
    test_redirect_flush();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined CPU.
- Holds the fetch PC and reads instruction memory combinationally.
- Buffers fetched {pc, instruction} pairs in a DEPTH-entry prefetch queue and hands them to ID over a valid/ready handshake.
- Branch/jump redirects flush the queue and reload the PC. A flush indication goes out to the rest of the pipeline.

Parameters:
- XLEN, 32, width of PC and instruction.
- IMEM_AW, 6, instruction-memory word-address width (PC bits [IMEM_AW+1:2]).
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  branch taken or jump this cycle.
- redirect_target  in  XLEN  new PC when redirect_valid.
- imem_addr  out  IMEM_AW  word address to instruction memory, = fetch_pc[IMEM_AW+1:2].
- imem_rdata  in  XLEN  instruction at imem_addr, same-cycle (combinational) read.
- id_valid  out  1  queue head valid.
- id_ready  in  1  ID accepts head this cycle; low = stall.
- id_instr  out  XLEN  head instruction; 0 when queue empty.
- id_pc  out  XLEN  PC of head instruction; 0 when queue empty.
- flush_out  out  1  = redirect_valid (combinational); ID squashes its current input.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset is synchronous, active-high, on clk; it overrides all other inputs.
- Reset values:
  - fetch_pc = RESET_PC.
  - Queue empty; q_count = 0, id_valid = 0, id_instr = 0, id_pc = 0.
  - flush_out follows redirect_valid even during reset.
- Pop: id_valid && id_ready && !redirect_valid.
- Push (fetch): !redirect_valid && (q_count < DEPTH || pop). Push writes {fetch_pc, imem_rdata} at the tail, and fetch_pc advances by 4, wrapping modulo 2^XLEN. Simultaneous push and pop when full is legal: count stays DEPTH, FIFO order is preserved.
- No push (queue full, no pop): fetch_pc holds.
- Redirect (redirect_valid=1):
  - Next cycle the queue is empty and fetch_pc = {redirect_target[XLEN-1:2], 2'b00}; misaligned low bits are silently cleared.
  - No push and no pop occur in the redirect cycle, regardless of id_ready.
  - First fetch from the new target happens in the cycle after redirect.
  - Redirect-to-ID latency: the target instruction reaches id_valid 2 cycles after the redirect edge.
- Consecutive redirects: the last one wins; the queue stays empty throughout.
- Latency, no stalls: the instruction at PC p is pushed in the cycle fetch_pc = p and is visible at the ID head the next cycle. Steady-state throughput is 1 instruction/cycle.
- Empty queue: id_valid = 0; id_ready is ignored.
- Queue pointers: head/tail are $clog2(DEPTH) bits and wrap naturally. q_count: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Reset mid-operation: queue contents are discarded and fetch restarts at RESET_PC. The first instruction is valid at ID 2 cycles after reset deasserts.
- No X on outputs: head data is forced to 0 when empty.

Decomposition:
- Shared package (cpu_pkg) holds:
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h0000_0000.
  - typedef fetch_entry_t {pc, instr}.
  - A function that aligns an address (clears bits [1:0]).
- One sub-module, fetch_queue: generic DEPTH-entry synchronous FIFO.
  - Interface: push/pop/flush, full/empty, count, head data.
  - flush has priority over push/pop.
- The top level holds fetch_pc, the push/pop/redirect logic, and the output muxing.

Test Plan:
- Reset then id_ready=1 continuously, imem word k = 0x1000+k: id_valid rises 2 cycles after reset release. id_pc sequence is 0,4,8,…; id_instr is 0x1000,0x1001,… one per cycle; q_count stays at 1.
- id_ready=0 for 8 cycles after reset: q_count climbs 1,2,3,4 and holds at 4, fetch_pc holds at 16. On id_ready=1, heads pc 0,4,8,12,16 appear in order with no gap or duplicate.
- Queue holds 3 entries, redirect_valid=1 with target 0x40 while id_ready=1: flush_out=1 that cycle and no pop is counted. Next cycle q_count=0 and id_valid=0; the following cycle id_pc=0x40.
- Redirect target 0x47: fetch resumes at 0x44; imem_addr = 0x11.
- Full queue with id_ready=1 held: push and pop in the same cycle, q_count stays 4, order preserved. Then reset asserted mid-stream: next cycle q_count=0, id_valid=0, fetch_pc=RESET_PC.
- Back-to-back redirects to 0x20 then 0x80: only pc 0x80 appears at ID, 2 cycles after the second redirect. No entry from 0x20 is ever valid.
